// File: rtl/pulse_width_decoder_pkg.sv
// Shared link constants for the pulse-stretch link: default pulse width, counter widths
// and the receive FSM state encoding (also used by the transmit-side generator).
package pulse_width_decoder_pkg;

   localparam int PULSE_LEN_DEF = 3;
   localparam int LEN_W_DEF     = 4;
   localparam int CNT_W_DEF     = 8;

   typedef enum logic [1:0] {
      S_ARM  = 2'd0,
      S_IDLE = 2'd1,
      S_HIGH = 2'd2,
      S_LONG = 2'd3
   } state_t;

endpackage

// File: rtl/pulse_dec_sync.sv
// Two-flop synchronizer with synchronous active-high reset to 0.
// Used by pulse_width_decoder only when PULSE_DEC_SYNC_EN is defined.
module pulse_dec_sync (
   input  logic Clk,
   input  logic Rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pulse_width_decoder.sv
// Receive end of the pulse-stretch link: one Evt per exact PULSE_LEN-wide high pulse on X.
// Define PULSE_DEC_SYNC_EN to put X through a 2-flop synchronizer (adds 2 cycles latency).
module pulse_width_decoder
   import pulse_width_decoder_pkg::*;
#(
   parameter int PULSE_LEN = PULSE_LEN_DEF,
   parameter int LEN_W     = LEN_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             X,
   output logic             Evt,
   output logic             ErrShort,
   output logic             ErrLong,
   output logic             Busy,
   output logic [CNT_W-1:0] EvtCount,
   output state_t           dbg_state
);

   localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(PULSE_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic             xs;
   state_t           state, state_nxt;
   logic [LEN_W-1:0] len, len_nxt;
   logic             evt_nxt, err_short_nxt, err_long_nxt;

`ifdef PULSE_DEC_SYNC_EN
   pulse_dec_sync u_sync (
      .Clk (Clk),
      .Rst (Rst),
      .d   (X),
      .q   (xs)
   );
`else
   assign xs = X;
`endif

   always_comb begin
      state_nxt     = state;
      len_nxt       = len;
      evt_nxt       = 1'b0;
      err_short_nxt = 1'b0;
      err_long_nxt  = 1'b0;
      case (state)
         // A pulse already in flight when reset drops is ignored until X goes low.
         S_ARM: begin
            if (!xs) state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (xs) begin
               state_nxt = S_HIGH;
               len_nxt   = LEN_W'(1);
            end
         end
         S_HIGH: begin
            if (xs) begin
               if (len == LEN_FULL) begin
                  state_nxt    = S_LONG;
                  err_long_nxt = 1'b1;
               end else begin
                  len_nxt = len + LEN_W'(1);
               end
            end else begin
               state_nxt = S_IDLE;
               len_nxt   = '0;
               if (len == LEN_FULL) evt_nxt = 1'b1;
               else                 err_short_nxt = 1'b1;
            end
         end
         S_LONG: begin
            if (!xs) begin
               state_nxt = S_IDLE;
               len_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_ARM;
            len_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= S_ARM;
         len      <= '0;
         Evt      <= 1'b0;
         ErrShort <= 1'b0;
         ErrLong  <= 1'b0;
         Busy     <= 1'b0;
         EvtCount <= '0;
      end else begin
         state    <= state_nxt;
         len      <= len_nxt;
         Evt      <= evt_nxt;
         ErrShort <= err_short_nxt;
         ErrLong  <= err_long_nxt;
         Busy     <= (state_nxt == S_HIGH) || (state_nxt == S_LONG);
         // Count holds at all-ones; Evt itself keeps pulsing.
         if (evt_nxt && (EvtCount != CNT_MAX)) EvtCount <= EvtCount + CNT_W'(1);
      end
   end

   assign dbg_state = state;

endmodule
